serial_ip_seq: RTL

Next-generation bit-serial inner-product lane for the Stripes NFU. It computes one output neuron as the dot product of TI neuron values, fed MSB-first one bit-slice per accepted beat, with TI parallel N-bit synapses. Runtime precision is set per operation. The block has its own sequencing FSM, input and output valid/ready handshakes, a configurable tree pipeline depth, output saturation, and accumulate, max and ReLU modes. Instances are tiled Tw x Tn by the NFU-1-2 wrapper.

---
 rtl/serial_ip_seq.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_ip_seq.sv
// serial_ip_seq
// Bit-serial inner-product lane. It computes one output neuron as the dot
// product of TI neuron values with TI parallel N-bit signed synapses.
// Neuron values arrive MSB-first, one bit-slice per accepted beat.
// The neuron precision p is chosen per operation. The lane has its own
// sequencing FSM and valid/ready handshakes on both the bit input and the
// result output.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   i_start        operation request, accepted only while o_busy=0
//   i_precision    neuron bits p (0 or >P_MAX selects P_MAX), sampled at start
//   i_mode         00/11 accumulate, 01 max vs i_nbout, 10 accumulate+ReLU
//   i_nbout        signed partial sum / max operand, sampled at start
//   i_syn_load     load i_synapses into the synapse register on this edge
//   i_synapses     TI packed signed synapses, lane i at [i*N+N-1:i*N]
//   i_bit_valid    bit-slice valid
//   i_neuron_bits  current bit of each lane's neuron, MSB first
//   o_bit_ready    high in RUN; a beat transfers on i_bit_valid & o_bit_ready
//   o_busy         high whenever the FSM is not IDLE
//   o_valid        result valid, held until i_ready
//   i_ready        downstream accept
//   o_result       signed N-bit result
//   o_sat          saturation occurred, qualified by o_valid
module serial_ip_seq #(
    parameter int N     = 16,
    parameter int TI    = 16,
    parameter int P_MAX = 16,
    parameter int PIPE  = 1,
    parameter int ACC_W = 40,
    parameter int SAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [4:0]      i_precision,
    input  logic [1:0]      i_mode,
    input  logic [N-1:0]    i_nbout,
    input  logic            i_syn_load,
    input  logic [TI*N-1:0] i_synapses,
    input  logic            i_bit_valid,
    input  logic [TI-1:0]   i_neuron_bits,
    output logic            o_bit_ready,
    output logic            o_busy,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [N-1:0]    o_result,
    output logic            o_sat
);

    localparam int LG   = $clog2(TI);
    // One guard bit above N+clog2(TI): negating TI copies of the most
    // negative synapse on the sign beat would otherwise wrap.
    localparam int TW   = N + LG + 1;
    localparam int CW   = $clog2(P_MAX + 1);
    localparam int HALF = TI / 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [4:0]    P_MAX5 = 5'(P_MAX);
    localparam logic [CW-1:0] P_MAXC = CW'(P_MAX);

    localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    first_q, first_d;
    logic [1:0]              mode_q, mode_d;
    logic [N-1:0]            nbout_q, nbout_d;
    logic [TI*N-1:0]         syn_q, syn_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N-1:0]            result_q, result_d;
    logic                    sat_q, sat_d;
    logic                    valid_q, valid_d;

    logic                    beat;
    logic [CW-1:0]           p_eff;
    logic signed [TW-1:0]    sum_lo, sum_hi;
    logic signed [TW-1:0]    tree_sum;
    logic signed [ACC_W-1:0] tree_se;
    logic                    tree_valid;
    logic                    pipe_busy_d;

    logic signed [ACC_W-1:0] sum_r;
    logic [N-1:0]            sat_acc, sat_sum;
    logic                    sat_acc_flag, sat_sum_flag;
    logic [N-1:0]            fin_result;
    logic                    fin_sat;

    // The returned value is {saturation flag, N-bit result}.
    function automatic logic [N:0] saturate(input logic signed [ACC_W-1:0] x);
        logic [N:0] r;
        r = {1'b0, x[N-1:0]};
        if (SAT != 0) begin
            if (x > RES_MAX) begin
                r = {1'b1, 1'b0, {(N-1){1'b1}}};
            end else if (x < RES_MIN) begin
                r = {1'b1, 1'b1, {(N-1){1'b0}}};
            end
        end
        return r;
    endfunction

    assign beat        = (state_q == S_RUN) && i_bit_valid;
    assign o_bit_ready = (state_q == S_RUN);
    assign o_busy      = (state_q != S_IDLE);
    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_sat       = sat_q;

    assign p_eff = ((i_precision == 5'd0) || (i_precision > P_MAX5)) ? P_MAXC : CW'(i_precision);

    // Lane products split into two half-trees so that an optional register
    // can sit at the tree midpoint. On the MSB beat every product is negated,
    // because that bit carries weight -2^(p-1).
    always_comb begin
        logic signed [TW-1:0] prod;
        sum_lo = '0;
        sum_hi = '0;
        prod   = '0;
        for (int i = 0; i < TI; i++) begin
            prod = i_neuron_bits[i] ? TW'($signed(syn_q[i*N +: N])) : '0;
            if (first_q) begin
                prod = -prod;
            end
            if (i < HALF) begin
                sum_lo = sum_lo + prod;
            end else begin
                sum_hi = sum_hi + prod;
            end
        end
    end

    generate
        if (PIPE == 1) begin : g_pipe
            logic signed [TW-1:0] mid_lo_q, mid_lo_d;
            logic signed [TW-1:0] mid_hi_q, mid_hi_d;
            logic                 mid_valid_q, mid_valid_d;

            always_comb begin
                mid_lo_d    = sum_lo;
                mid_hi_d    = sum_hi;
                mid_valid_d = beat;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    mid_lo_q    <= '0;
                    mid_hi_q    <= '0;
                    mid_valid_q <= 1'b0;
                end else begin
                    mid_lo_q    <= mid_lo_d;
                    mid_hi_q    <= mid_hi_d;
                    mid_valid_q <= mid_valid_d;
                end
            end

            assign tree_sum    = mid_lo_q + mid_hi_q;
            assign tree_valid  = mid_valid_q;
            // A beat is still in flight after this edge exactly when one
            // enters the midpoint register on it.
            assign pipe_busy_d = mid_valid_d;
        end else begin : g_comb
            assign tree_sum    = sum_lo + sum_hi;
            assign tree_valid  = beat;
            assign pipe_busy_d = 1'b0;
        end
    endgenerate

    assign tree_se = ACC_W'(tree_sum);

    // Final result: in max mode the comparison uses the saturated
    // accumulator; the other modes add nbout first. ReLU applies after
    // saturation.
    always_comb begin
        sum_r                      = acc_q + ACC_W'($signed(nbout_q));
        {sat_acc_flag, sat_acc}    = saturate(acc_q);
        {sat_sum_flag, sat_sum}    = saturate(sum_r);
        fin_result                 = sat_sum;
        fin_sat                    = sat_sum_flag;
        case (mode_q)
            2'b01: begin
                fin_sat    = sat_acc_flag;
                fin_result = ($signed(sat_acc) > $signed(nbout_q)) ? sat_acc : nbout_q;
            end
            2'b10: begin
                if (sat_sum[N-1]) begin
                    fin_result = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencing FSM and accumulator next-state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        mode_d   = mode_q;
        nbout_d  = nbout_q;
        acc_d    = acc_q;
        result_d = result_q;
        sat_d    = sat_q;
        valid_d  = valid_q;
        syn_d    = i_syn_load ? i_synapses : syn_q;

        if (tree_valid) begin
            acc_d = (acc_q <<< 1) + tree_se;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    cnt_d   = p_eff;
                    first_d = 1'b1;
                    mode_d  = i_mode;
                    nbout_d = i_nbout;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                if (beat) begin
                    cnt_d   = cnt_q - CW'(1);
                    first_d = 1'b0;
                    if (cnt_q == CW'(1)) begin
                        state_d = pipe_busy_d ? S_DRAIN : S_FINISH;
                    end
                end
            end
            S_DRAIN: begin
                if (!pipe_busy_d) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                result_d = fin_result;
                sat_d    = fin_sat;
                valid_d  = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            mode_q   <= '0;
            nbout_q  <= '0;
            syn_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            mode_q   <= mode_d;
            nbout_q  <= nbout_d;
            syn_q    <= syn_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
        end
    end

endmodule
